pattern_detector_param: RTL and testbench
=========================================

PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter LEN_W, default 4: width of cfg_len; must hold MAX_LEN.
REQ-003 SHALL have parameter CNT_W, default 8: width of match_count.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_bit is sampled on this edge.
REQ-007 in_bit  input  1  serial data bit.
REQ-008 cfg_load  input  1  load cfg_pattern, cfg_len and cfg_overlap on this edge.
REQ-009 cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
REQ-010 cfg_len  input  LEN_W  pattern length in bits.
REQ-011 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-012 cnt_clr  input  1  synchronous clear of match_count.
REQ-013 detected  output  1  registered one-cycle pulse per match.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 cfg_error  output  1  last cfg_load carried an illegal length.
REQ-016 armed  output  1  a legal configuration is loaded.

Function
REQ-017 SHALL implement FSM states UNCFG (no legal configuration), FILL (fewer than len valid bits held) and RUN (at least len valid bits held).
REQ-018 cfg_load with 2 <= cfg_len <= MAX_LEN SHALL latch the configuration, clear the history and fill count, clear cfg_error, and go to FILL.
REQ-019 cfg_load with cfg_len < 2 or cfg_len > MAX_LEN SHALL set cfg_error, go to UNCFG and leave the stored pattern unchanged.
REQ-020 In UNCFG, in_valid SHALL be ignored.
REQ-021 An accepted bit SHALL shift into history[0], move older bits up, and increment the fill count, saturating at len; FILL goes to RUN when the count reaches len.
REQ-022 detected SHALL be 1 on the edge that samples the completing bit when the len newest bits, including that bit, equal cfg_pattern[len-1:0]; there is no further latency.
REQ-023 detected SHALL be 0 in every other cycle, including cycles where in_valid = 0.
REQ-024 On a match with overlap = 1, state SHALL stay RUN with the history kept.
REQ-025 On a match with overlap = 0, the fill count SHALL be cleared and state SHALL go to FILL.
REQ-026 match_count SHALL increment on each match and hold at 2^CNT_W-1.
REQ-027 cnt_clr SHALL zero match_count; if a match occurs on the same edge, the result SHALL be 1.
REQ-028 cfg_load on the same edge as in_valid SHALL take priority; the bit SHALL be discarded and detected SHALL be 0.
REQ-029 cfg_load SHALL NOT change match_count.
REQ-030 armed SHALL be 1 exactly when state is FILL or RUN.

Reset
REQ-031 rst_n low SHALL immediately force: state UNCFG, history 0, fill count 0, stored pattern 0, len 0, overlap 0, detected 0, match_count 0, cfg_error 0, armed 0.
REQ-032 Reset mid-stream SHALL discard any partial match; after release, no detection SHALL occur until a new legal cfg_load.

Structure
REQ-033 The shared package pattern_det_pkg SHALL hold the state encodings (UNCFG = 2'b00, FILL = 2'b01, RUN = 2'b10) and the minimum length constant (2).
REQ-034 The masked compare SHALL be a sub-module pattern_match_cmp: inputs history, pattern and len; combinational output eq.
REQ-035 The FSM, history register and counter SHALL reside in the top module.

Verification
REQ-036 Load 101, len 3, overlap 1; feed 1,0,1,0,1,1,0,0,1,0,1 -> detected pulses on the 3rd, 5th and 11th bits; match_count = 3.
REQ-037 Same stream with overlap 0 -> pulses on the 3rd and 11th bits only; match_count = 2.
REQ-038 Load 0xA5, len 8; feed 1010_0101 twice, first bit first -> pulses on the 8th and 16th bits, with overlap 1 and 0 alike.
REQ-039 cfg_load with len 0, then len 9 (MAX_LEN = 8) -> cfg_error = 1, armed = 0; a following legal load -> cfg_error = 0, armed = 1, pattern updated.
REQ-040 CNT_W = 2, 5 matches -> match_count = 3; cnt_clr together with a 6th match -> match_count = 1.
REQ-041 Deassert rst_n after the bits 1,0 of a 101 pattern -> all outputs 0 asynchronously; a following 1 -> no detection; armed = 0.

Source files
------------

// File: rtl/pattern_det_pkg.sv
// -----------------------------------------------------------------------------
// pattern_det_pkg
//
// Shared definitions for the serial pattern detector:
//   state_t      - detector FSM state encoding (UNCFG / FILL / RUN)
//   MIN_LEN      - shortest pattern length accepted by a cfg_load
//   len_is_legal - range check applied to a requested pattern length
// -----------------------------------------------------------------------------
package pattern_det_pkg;

    // UNCFG : no legal configuration loaded, incoming bits are ignored
    // FILL  : configured, fewer than len valid bits collected since last clear
    // RUN   : configured, at least len valid bits collected
    typedef enum logic [1:0] {
        UNCFG = 2'b00,
        FILL  = 2'b01,
        RUN   = 2'b10
    } state_t;

    localparam int MIN_LEN = 2;

    // A pattern length is usable when it lies in MIN_LEN..max_len inclusive.
    function automatic logic len_is_legal(input int len, input int max_len);
        return (len >= MIN_LEN) && (len <= max_len);
    endfunction

endpackage : pattern_det_pkg

// File: rtl/pattern_match_cmp.sv
// -----------------------------------------------------------------------------
// pattern_match_cmp
//
// Combinational masked comparator: reports whether the len least-significant
// bits of history equal the len least-significant bits of pattern. Bits at or
// above position len are ignored.
//
// Ports
//   history [MAX_LEN-1:0] in  : newest bit at [0], older bits above it
//   pattern [MAX_LEN-1:0] in  : reference pattern, last-received bit at [0]
//   len     [LEN_W-1:0]   in  : number of low-order bits taking part
//   eq                    out : 1 when every compared bit matches
// -----------------------------------------------------------------------------
module pattern_match_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] history,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               eq
);

    logic [MAX_LEN-1:0] mask;

    // Thermometer mask: bit i enabled when i < len.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign eq = (((history ^ pattern) & mask) == '0);

endmodule : pattern_match_cmp

// File: rtl/pattern_detector_param.sv
// -----------------------------------------------------------------------------
// pattern_detector_param
//
// Serial bit-pattern detector with a runtime-loadable pattern of 2..MAX_LEN
// bits, optional overlapping matches and a saturating match counter.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   in_bit is accepted on this edge (ignored when unarmed)
//   in_bit       in   serial data bit
//   cfg_load     in   load cfg_pattern / cfg_len / cfg_overlap on this edge;
//                     wins over in_valid on the same edge (bit is dropped)
//   cfg_pattern  in   pattern; bit [cfg_len-1] is received first, bit [0] last
//   cfg_len      in   pattern length in bits
//   cfg_overlap  in   1 = overlapping matches, 0 = restart collection after a match
//   cnt_clr      in   synchronous clear of match_count (a same-edge match leaves 1)
//   detected     out  registered one-cycle pulse on the edge taking the completing bit
//   match_count  out  saturating count of matches
//   cfg_error    out  last cfg_load carried an illegal length
//   armed        out  a legal configuration is loaded (state FILL or RUN)
//   dbg_state    out  current FSM state, for observation only
//
// Handshake: there is no backpressure. A bit is consumed on every rising edge
// where in_valid = 1, cfg_load = 0 and the detector is armed; the result of
// that bit appears on detected right after the same edge.
// -----------------------------------------------------------------------------
module pattern_detector_param
    import pattern_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_error,
    output logic               armed,
    output state_t             dbg_state
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t               state_q, state_d;
    // Only MAX_LEN-1 past bits are ever needed: together with the incoming bit
    // they form the full MAX_LEN-bit window that is compared.
    logic [MAX_LEN-2:0]   hist_q,  hist_d;
    logic [LEN_W-1:0]     fill_q,  fill_d;
    logic [MAX_LEN-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]     len_q,   len_d;
    logic                 ovl_q,   ovl_d;
    logic                 det_q,   det_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 err_q,   err_d;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic [MAX_LEN-1:0]   window;     // history after shifting in in_bit
    logic [LEN_W-1:0]     fill_inc;   // fill count after accepting in_bit
    logic                 is_armed;
    logic                 accept;
    logic                 cmp_eq;
    logic                 match;
    logic                 cfg_legal;

    assign window    = {hist_q, in_bit};
    assign fill_inc  = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : len_q;
    assign is_armed  = (state_q == FILL) || (state_q == RUN);
    assign accept    = in_valid && !cfg_load && is_armed;
    assign cfg_legal = len_is_legal(int'(cfg_len), MAX_LEN);

    pattern_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .history (window),
        .pattern (pat_q),
        .len     (len_q),
        .eq      (cmp_eq)
    );

    // A match needs len valid bits including the incoming one.
    assign match = accept && (fill_inc == len_q) && cmp_eq;

    // -------------------------------------------------------------------------
    // Next-state / next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        det_d   = 1'b0;
        cnt_d   = cnt_q;

        if (cfg_load) begin
            if (cfg_legal) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                err_d   = 1'b0;
                state_d = FILL;
            end else begin
                // Stored configuration is kept; only the error flag and the
                // state change.
                err_d   = 1'b1;
                state_d = UNCFG;
            end
        end else if (accept) begin
            hist_d  = window[MAX_LEN-2:0];
            fill_d  = fill_inc;
            state_d = (fill_inc == len_q) ? RUN : FILL;
            if (match) begin
                det_d = 1'b1;
                if (!ovl_q) begin
                    // Non-overlapping: the next match must be built from
                    // entirely new bits.
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end

        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            det_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign detected    = det_q;
    assign match_count = cnt_q;
    assign cfg_error   = err_q;
    assign armed       = is_armed;
    assign dbg_state   = state_q;

endmodule : pattern_detector_param

// File: tb/tb_pattern_detector_param.sv
// -----------------------------------------------------------------------------
// tb_pattern_detector_param
//
// Two detector instances share one stimulus stream: u_dut with default
// parameters and u_dut2 with CNT_W = 2 for counter saturation. The driver
// updates a bit-list reference model on every cycle and pushes the expected
// outputs; the monitor pops and compares after each rising edge.
// -----------------------------------------------------------------------------
module tb_pattern_detector_param;
    import pattern_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int EW      = 15; // {det, cnt8[7:0], cnt2[1:0], err, armed, state[1:0]}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic               in_valid    = 1'b0;
    logic               in_bit      = 1'b0;
    logic               cfg_load    = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len     = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr     = 1'b0;

    logic               detected,  detected2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;
    logic               cfg_error, cfg_error2;
    logic               armed,     armed2;
    state_t             dbg_state, dbg_state2;

    pattern_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .detected(detected),
        .match_count(match_count), .cfg_error(cfg_error), .armed(armed),
        .dbg_state(dbg_state)
    );

    pattern_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .detected(detected2),
        .match_count(match_count2), .cfg_error(cfg_error2), .armed(armed2),
        .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bits collected since the last configuration or non-overlapping match,
    // oldest first. A match is simply "the last len bits spell the pattern".
    logic [7:0] m_pat   = '0;
    int         m_len   = 0;
    logic       m_ovl   = 1'b0;
    logic       m_armed = 1'b0;
    logic       m_err   = 1'b0;
    int         c8      = 0;
    int         c2      = 0;
    int         bq[$];

    task automatic model_reset();
        m_pat = '0; m_len = 0; m_ovl = 1'b0; m_armed = 1'b0; m_err = 1'b0;
        c8 = 0; c2 = 0;
        bq.delete();
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic v, input logic b, input logic clr);
        logic det;
        int   st;
        @(negedge clk);
        cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        in_valid = v; in_bit = b; cnt_clr = clr;

        det = 1'b0;
        if (ld) begin
            if (int'(len) >= 2 && int'(len) <= MAX_LEN) begin
                m_pat = pat; m_len = int'(len); m_ovl = ovl;
                m_armed = 1'b1; m_err = 1'b0;
                bq.delete();
            end else begin
                m_armed = 1'b0; m_err = 1'b1;
            end
        end else if (v && m_armed) begin
            bq.push_back(b ? 1 : 0);
            if (bq.size() > 32) void'(bq.pop_front());
            if (bq.size() >= m_len) begin
                det = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (bq[bq.size() - 1 - k] != (m_pat[k] ? 1 : 0)) det = 1'b0;
                end
            end
            if (det && !m_ovl) bq.delete();
        end

        if (clr) begin
            c8 = det ? 1 : 0;
            c2 = det ? 1 : 0;
        end else if (det) begin
            if (c8 < 255) c8++;
            if (c2 < 3)   c2++;
        end

        st = !m_armed ? 0 : ((bq.size() >= m_len) ? 2 : 1);
        exp_q.push_back({det, 8'(c8), 2'(c2), m_err, m_armed, 2'(st)});
    endtask

    task automatic idle(input logic clr);
        drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, clr);
    endtask

    task automatic feed(input logic b);
        drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0);
    endtask

    // Wait until the last driven cycle has been applied and checked.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("detected",     32'(detected),     32'(e[14]));
                check("detected2",    32'(detected2),    32'(e[14]));
                check("match_count",  32'(match_count),  32'(e[13:6]));
                check("match_count2", 32'(match_count2), 32'(e[5:4]));
                check("cfg_error",    32'(cfg_error),    32'(e[3]));
                check("armed",        32'(armed),        32'(e[2]));
                check("state",        32'(dbg_state),    32'(e[1:0]));
                check("state2",       32'(dbg_state2),   32'(e[1:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [10:0] s36 = 11'b10101100101;
    logic [15:0] s38 = 16'hA5A5;

    initial begin
        // Reset state
        #12;
        check("rst_detected", 32'(detected),    0);
        check("rst_count",    32'(match_count), 0);
        check("rst_cfg_err",  32'(cfg_error),   0);
        check("rst_armed",    32'(armed),       0);
        check("rst_state",    32'(dbg_state),   32'(UNCFG));
        @(negedge clk);
        rst_n = 1'b1;

        // Bits offered before any configuration are ignored
        feed(1'b1); feed(1'b0);

        // 101 overlapping: pulses on bits 3, 5, 11
        idle(1'b1);
        drive(1'b1, 8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 10; i >= 0; i--) feed(s36[i]);
        settle();
        check("ovl_count", 32'(match_count), 3);

        // 101 non-overlapping: pulses on bits 3, 11
        idle(1'b1);
        drive(1'b1, 8'b101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 10; i >= 0; i--) feed(s36[i]);
        settle();
        check("novl_count", 32'(match_count), 2);

        // 0xA5 full length, both overlap modes
        for (int o = 0; o < 2; o++) begin
            idle(1'b1);
            drive(1'b1, 8'hA5, 4'd8, o[0], 1'b0, 1'b0, 1'b0);
            for (int i = 15; i >= 0; i--) feed(s38[i]);
            settle();
            check("a5_count", 32'(match_count), 2);
        end

        // Illegal lengths, then recovery with a new pattern
        drive(1'b1, 8'h03, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        feed(1'b1); feed(1'b1);
        drive(1'b1, 8'h03, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("bad_len_err",   32'(cfg_error), 1);
        check("bad_len_armed", 32'(armed),     0);
        drive(1'b1, 8'b0110, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("good_len_err",   32'(cfg_error), 0);
        check("good_len_armed", 32'(armed),     1);
        feed(1'b0); feed(1'b1); feed(1'b1); feed(1'b0); feed(1'b1); feed(1'b1); feed(1'b0);

        // Counter saturation on the 2-bit instance, then clear with a match
        idle(1'b1);
        drive(1'b1, 8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) feed(1'b1);
        settle();
        check("sat_count2", 32'(match_count2), 3);
        check("sat_count8", 32'(match_count),  5);
        drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        check("clr_match_count2", 32'(match_count2), 1);

        // Load on the same edge as a valid bit: bit dropped
        drive(1'b1, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        feed(1'b1); feed(1'b1);

        // Asynchronous reset mid-pattern
        drive(1'b1, 8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        feed(1'b1); feed(1'b0);
        settle();
        rst_n = 1'b0;
        #1;
        check("arst_detected", 32'(detected),    0);
        check("arst_count",    32'(match_count), 0);
        check("arst_cfg_err",  32'(cfg_error),   0);
        check("arst_armed",    32'(armed),       0);
        check("arst_state",    32'(dbg_state),   32'(UNCFG));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        feed(1'b1);
        settle();
        check("post_rst_det",   32'(detected), 0);
        check("post_rst_armed", 32'(armed),    0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic       ld;
            logic [3:0] ln;
            ld = ($urandom_range(0, 39) == 0);
            ln = ($urandom_range(0, 15) < 12) ? 4'($urandom_range(2, 4)) : 4'($urandom_range(0, 15));
            drive(ld, 8'($urandom_range(0, 255)), ln, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0));
        end
        idle(1'b0);

        // Drain
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) settle();
        check("drain", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pattern_detector_param
